// File: rtl/scmemsum_engine.sv
// Memory-side block engine for the 32-word data RAM: sums a block of words into a
// destination word (op=0) or copies a block forward to a destination block (op=1).
module scmemsum_engine #(
  parameter int CW = 6,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          op,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [CW-1:0] count,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_datain,
  input  logic [31:0]   mem_dataout,
  output logic          busy,
  output logic          done,
  output logic [31:0]   result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_DONE
  } state_e;

  localparam logic OP_SUM = 1'b0;

  state_e        state_q, state_d;
  logic          op_q, op_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] k_q, k_d;
  logic [31:0]   acc_q, acc_d;
  logic [31:0]   buf_q, buf_d;
  logic [31:0]   result_q, result_d;
  logic [AW-1:0] addr_hold_q;
  logic [31:0]   data_hold_q;

  logic [AW-1:0] k_off;
  logic          last;

  assign k_off  = AW'({k_q, 2'b00});
  assign last   = (k_q == (cnt_q - CW'(1)));
  assign result = result_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    src_d      = src_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    acc_d      = acc_q;
    buf_d      = buf_q;
    result_d   = result_q;
    mem_we     = 1'b0;
    // address/data buses keep their last driven value outside RD/WR
    mem_addr   = addr_hold_q;
    mem_datain = data_hold_q;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          src_d = src_addr & ~AW'(3);
          dst_d = dst_addr & ~AW'(3);
          cnt_d = count;
          acc_d = '0;
          k_d   = '0;
          if (count != '0) begin
            state_d = S_RD;
          end else if (op == OP_SUM) begin
            state_d = S_WR;
          end else begin
            state_d  = S_DONE;
            result_d = '0;
          end
        end
      end
      S_RD: begin
        busy     = 1'b1;
        mem_addr = src_q + k_off;
        acc_d    = acc_q + mem_dataout;
        if (op_q == OP_SUM) begin
          k_d = k_q + CW'(1);
          if (last) state_d = S_WR;
        end else begin
          buf_d   = mem_dataout;
          state_d = S_WR;
        end
      end
      S_WR: begin
        busy   = 1'b1;
        mem_we = 1'b1;
        if (op_q == OP_SUM) begin
          mem_addr   = dst_q;
          mem_datain = acc_q;
          state_d    = S_DONE;
          result_d   = acc_q;
        end else begin
          mem_addr   = dst_q + k_off;
          mem_datain = buf_q;
          k_d        = k_q + CW'(1);
          if (last) begin
            state_d  = S_DONE;
            result_d = acc_q;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
      cnt_q       <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      buf_q       <= '0;
      result_q    <= '0;
      addr_hold_q <= '0;
      data_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      buf_q       <= buf_d;
      result_q    <= result_d;
      addr_hold_q <= mem_addr;
      data_hold_q <= mem_datain;
    end
  end

endmodule

// File: tb/tb_scmemsum_engine.sv
// Scoreboard bench for scmemsum_engine: directed block sum/copy vectors against a
// bench-owned 32-word RAM; expected writes and completions are queued at issue time.
module tb_scmemsum_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [5:0]  count = '0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_datain;
  logic [31:0] mem_dataout;
  logic        busy;
  logic        done;
  logic [31:0] result;

  scmemsum_engine #(.CW(6), .AW(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .src_addr(src_addr), .dst_addr(dst_addr), .count(count),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_datain(mem_datain),
    .mem_dataout(mem_dataout), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // RAM with a bench-side preload port
  logic [31:0] ram [32];
  logic        tb_we = 1'b0;
  logic [4:0]  tb_idx = '0;
  logic [31:0] tb_val = '0;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[6:2]] <= mem_datain;
    else if (tb_we) ram[tb_idx] <= tb_val;
  end
  assign mem_dataout = ram[mem_addr[6:2]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int s; int lat; logic [31:0] res; } dn_t;
  wr_t wr_q[$];
  dn_t dn_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: pops expectations whenever the DUT writes or completes
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        if (wr_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_datain);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_data", mem_datain, e.data);
        end
      end
      if (done) begin
        if (dn_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_done: got done=1 expected 0");
        end else begin
          dn_t d;
          d = dn_q.pop_front();
          chk("latency", 32'(cyc - d.s), 32'(d.lat));
          chk("result", result, d.res);
          chk("busy_at_done", {31'b0, busy}, 32'd0);
        end
      end
    end
  end

  task automatic poke(input int idx, input logic [31:0] val);
    tb_idx = 5'(idx);
    tb_val = val;
    tb_we  = 1'b1;
    @(negedge clk); #2;
    tb_we  = 1'b0;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a; e.data = d;
    wr_q.push_back(e);
  endtask

  task automatic push_dn(input int lat, input logic [31:0] res);
    dn_t d;
    d.s = cyc; d.lat = lat; d.res = res;
    dn_q.push_back(d);
  endtask

  task automatic do_start(input logic o, input logic [31:0] s, input logic [31:0] d, input logic [5:0] n);
    op = o; src_addr = s; dst_addr = d; count = n;
    start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (dn_q.size() == 0 && wr_q.size() == 0 && !busy && !done) return;
      @(negedge clk); #2;
    end
    n_vec++; n_err++;
    $display("FAIL timeout: got busy=%0b pending_done=%0d expected idle", busy, dn_q.size());
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = '0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk); #2;

    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_datain", mem_datain, 32'd0);
    chk("rst_result", result, 32'd0);

    // block sum: a3+27+79+115 = 258
    poke(20, 32'h0000_00a3);
    poke(21, 32'h0000_0027);
    poke(22, 32'h0000_0079);
    poke(23, 32'h0000_0115);
    push_wr(32'h60, 32'h0000_0258);
    push_dn(6, 32'h0000_0258);
    do_start(1'b0, 32'h50, 32'h60, 6'd4);
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    wait_idle();
    chk("ram_sum_word", ram[24], 32'h0000_0258);
    chk("hold_addr", mem_addr, 32'h60);
    chk("hold_datain", mem_datain, 32'h0000_0258);
    chk("hold_result", result, 32'h0000_0258);

    // unaligned src and a start pulse while busy must both be harmless
    push_wr(32'h64, 32'h0000_0258);
    push_dn(6, 32'h0000_0258);
    do_start(1'b0, 32'h53, 32'h64, 6'd4);
    @(negedge clk); #2;
    do_start(1'b1, 32'h00, 32'h40, 6'd3);
    wait_idle();
    chk("ram_sum_word2", ram[25], 32'h0000_0258);
    chk("ram_ignored_dst", ram[16], 32'd0);

    // 32-bit wrap of the accumulator
    poke(0, 32'hffff_ffff);
    poke(1, 32'h0000_0002);
    push_wr(32'h08, 32'h0000_0001);
    push_dn(4, 32'h0000_0001);
    do_start(1'b0, 32'h00, 32'h08, 6'd2);
    wait_idle();
    chk("ram_ovf_word", ram[2], 32'h0000_0001);

    // forward copy of four words
    push_wr(32'h00, 32'h0000_00a3);
    push_wr(32'h04, 32'h0000_0027);
    push_wr(32'h08, 32'h0000_0079);
    push_wr(32'h0c, 32'h0000_0115);
    push_dn(9, 32'h0000_0258);
    do_start(1'b1, 32'h50, 32'h00, 6'd4);
    wait_idle();
    chk("ram_copy0", ram[0], 32'h0000_00a3);
    chk("ram_copy3", ram[3], 32'h0000_0115);

    // zero-length sum writes 0; zero-length copy writes nothing
    poke(4, 32'h0000_1234);
    push_wr(32'h10, 32'd0);
    push_dn(2, 32'd0);
    do_start(1'b0, 32'h50, 32'h10, 6'd0);
    wait_idle();
    chk("ram_zero_sum", ram[4], 32'd0);
    push_dn(1, 32'd0);
    do_start(1'b1, 32'h50, 32'h20, 6'd0);
    wait_idle();

    // reset during the k=1 write of a copy
    poke(0, 32'h11);
    poke(1, 32'h22);
    poke(2, 32'h33);
    poke(3, 32'h44);
    push_wr(32'h00, 32'h0000_00a3);
    push_wr(32'h04, 32'h0000_0027);
    do_start(1'b1, 32'h50, 32'h00, 6'd4);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk); #2;
    rst = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_we", {31'b0, mem_we}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    repeat (12) @(negedge clk);
    #2;
    chk("abort_ram0", ram[0], 32'h0000_00a3);
    chk("abort_ram1", ram[1], 32'h0000_0027);
    chk("abort_ram2", ram[2], 32'h33);
    chk("abort_ram3", ram[3], 32'h44);

    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    chk("dn_q_drained", 32'(dn_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
